// File: rtl/mem_load_unit.sv
// Load-side memory port: req/ack handshake, memory-data register, big-endian byte/half/word extraction.
// Optional build macro MEM_LOAD_ALIGN_CHECK_EN flags misaligned lh/lhu/lw without touching memory.
module mem_load_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] addr,
  input  logic [2:0]       ltype,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       ltype_q, ltype_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       sel_q, sel_d;
  logic             misalign;

  // Selection is frozen at capture time so rdata survives later starts and timeouts.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] lt);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (lt)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MEM_LOAD_ALIGN_CHECK_EN
  always_comb begin
    case (ltype)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = addr[0];
      default:        misalign = (addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ltype_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mdr_q   <= '0;
      off_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ltype_q <= ltype_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mdr_q   <= mdr_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ltype_d = ltype_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mdr_d   = mdr_q;
    off_d   = off_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          ltype_d = ltype;
          cnt_d   = '0;
          err_d   = misalign;
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        // An ack in the same cycle as the limit takes priority over the timeout.
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          off_d   = addr_q[1:0];
          sel_d   = ltype_q;
          state_d = DONE;
        end else if (cnt_q == TMO) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mem_req  = (state_q == REQ);
  assign err      = err_q;
  assign mem_addr = {addr_q[WIDTH-1:2], 2'b00};
  assign rdata    = extract(mdr_q, off_q, sel_q);

endmodule
